// File: rtl/button_pkg.sv
// Shared types and default constants for the button conditioner.
package button_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

   localparam int DEF_N_CH          = 4;
   localparam int DEF_DB_CYCLES     = 1000000;
   localparam int DEF_REPEAT_EN     = 1;
   localparam int DEF_REPEAT_DELAY  = 50000000;
   localparam int DEF_REPEAT_PERIOD = 10000000;

   // Counter width able to hold values up to v-1 with one bit of headroom.
   function automatic int cnt_width(input int v);
      return $clog2(v) + 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One input bit: 2-flop synchronizer, debounce counter, press/release pulses and
// the optional auto-repeat FSM (IDLE -> HOLD -> REPEAT, back to IDLE on release).
module button_channel
   import button_pkg::*;
#(
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int REPEAT_EN     = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic       clk,
   input  logic       rst_ext,
   input  logic       raw,
   output logic       level,
   output logic       press,
   output logic       rel,
   output logic       rpt,
   output logic [1:0] state_dbg
);

   localparam int DB_W = cnt_width(DB_CYCLES);

   logic            s1, s;
   logic [DB_W-1:0] db_cnt;
   logic            db_hit, rise, fall;

   always_comb begin
      db_hit = (s != level) && (db_cnt == DB_W'(DB_CYCLES - 1));
      rise   = db_hit && !level;
      fall   = db_hit && level;
   end

   always_ff @(posedge clk) begin
      if (rst_ext) begin
         s1     <= 1'b0;
         s      <= 1'b0;
         db_cnt <= '0;
         level  <= 1'b0;
         press  <= 1'b0;
         rel    <= 1'b0;
      end else begin
         s1    <= raw;
         s     <= s1;
         press <= rise;
         rel   <= fall;
         // Any agreeing cycle restarts the debounce window.
         if (s == level) begin
            db_cnt <= '0;
         end else if (db_hit) begin
            db_cnt <= '0;
            level  <= ~level;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   generate
      if (REPEAT_EN != 0) begin : g_rpt
         localparam int HW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

         rpt_state_t    st;
         logic [HW-1:0] hcnt;

         assign state_dbg = st;

         // Release takes priority: a rpt due in the same cycle is dropped.
         always_ff @(posedge clk) begin
            if (rst_ext) begin
               st   <= IDLE;
               hcnt <= '0;
               rpt  <= 1'b0;
            end else begin
               rpt <= 1'b0;
               case (st)
                  IDLE: begin
                     hcnt <= '0;
                     if (rise) st <= HOLD;
                  end
                  HOLD: begin
                     if (fall) begin
                        st   <= IDLE;
                        hcnt <= '0;
                     end else if (hcnt == HW'(REPEAT_DELAY - 1)) begin
                        st   <= REPEAT;
                        hcnt <= '0;
                        rpt  <= 1'b1;
                     end else begin
                        hcnt <= hcnt + 1'b1;
                     end
                  end
                  REPEAT: begin
                     if (fall) begin
                        st   <= IDLE;
                        hcnt <= '0;
                     end else if (hcnt == HW'(REPEAT_PERIOD - 1)) begin
                        hcnt <= '0;
                        rpt  <= 1'b1;
                     end else begin
                        hcnt <= hcnt + 1'b1;
                     end
                  end
                  default: begin
                     st   <= IDLE;
                     hcnt <= '0;
                  end
               endcase
            end
         end
      end else begin : g_no_rpt
         assign rpt       = 1'b0;
         assign state_dbg = IDLE;
      end
   endgenerate

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent debounced button channels with press/release/auto-repeat pulses.
// dbg_state exposes each channel's repeat FSM state, two bits per channel.
module button_conditioner
   import button_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int REPEAT_EN     = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              rst_ext,
   input  logic [N_CH-1:0]   raw,
   output logic [N_CH-1:0]   level,
   output logic [N_CH-1:0]   press,
   output logic [N_CH-1:0]   rel,
   output logic [N_CH-1:0]   rpt,
   output logic [2*N_CH-1:0] dbg_state
);

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
         ) u_ch (
            .clk      (clk),
            .rst_ext  (rst_ext),
            .raw      (raw[i]),
            .level    (level[i]),
            .press    (press[i]),
            .rel      (rel[i]),
            .rpt      (rpt[i]),
            .state_dbg(dbg_state[2*i +: 2])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=12, REPEAT_PERIOD=3.
module tb_button_conditioner;

   localparam int N_CH = 4;
   localparam int DB   = 4;
   localparam int RD   = 12;
   localparam int RP   = 3;

   logic            clk = 1'b0;
   logic            rst_ext;
   logic [N_CH-1:0] raw;
   logic [N_CH-1:0] level, press, rel, rpt;
   logic [2*N_CH-1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .N_CH(N_CH), .DB_CYCLES(DB), .REPEAT_EN(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst_ext(rst_ext), .raw(raw), .level(level), .press(press),
      .rel(rel), .rpt(rpt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_level"}, {28'd0, level}, 32'd0);
      chk({tag, "_press"}, {28'd0, press}, 32'd0);
      chk({tag, "_rel"},   {28'd0, rel},   32'd0);
      chk({tag, "_rpt"},   {28'd0, rpt},   32'd0);
   endtask

   logic [5:0] bounce;
   logic [3:0] exp_rpt, exp_rel;

   initial begin
      rst_ext = 1'b1;
      raw     = '0;
      bounce  = 6'b101101;

      // Reset state
      tick(); tick(); tick();
      chk_quiet("reset");
      chk("reset_state", {24'd0, dbg_state}, 32'd0);
      rst_ext = 1'b0;
      tick(); tick();
      chk_quiet("post_reset");

      // Clean rise on channel 0: level and press 6 cycles later
      raw[0] = 1'b1;
      for (int k = 1; k <= 5; k++) tick();
      chk("c0_level_early", {28'd0, level}, 32'd0);
      tick();
      chk("c0_level", {28'd0, level}, 32'h1);
      chk("c0_press", {28'd0, press}, 32'h1);
      chk("c0_rel",   {28'd0, rel},   32'd0);
      tick();
      chk("c0_press_one", {28'd0, press}, 32'd0);
      chk("c0_level_hold", {28'd0, level}, 32'h1);
      chk("c0_hold_state", {30'd0, dbg_state[1:0]}, 32'd1);
      raw[0] = 1'b0;
      for (int k = 1; k <= 6; k++) tick();
      chk("c0_rel_pulse", {28'd0, rel}, 32'h1);
      chk("c0_level_fall", {28'd0, level}, 32'd0);
      chk("c0_rpt_none", {28'd0, rpt}, 32'd0);
      tick();
      chk("c0_rel_one", {28'd0, rel}, 32'd0);
      chk("c0_idle_state", {30'd0, dbg_state[1:0]}, 32'd0);

      // 3-cycle glitch on channel 3 is rejected
      raw[3] = 1'b1;
      tick(); tick(); tick();
      raw[3] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_quiet("c3_glitch");
      end

      // Bounce on channel 1 then stable high
      for (int k = 5; k >= 0; k--) begin
         raw[1] = bounce[k];
         tick();
         chk("c1_bounce_level", {28'd0, level}, 32'd0);
      end
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk("c1_settle_level", {28'd0, level}, 32'd0);
      end
      tick();
      chk("c1_level", {28'd0, level}, 32'h2);
      chk("c1_press", {28'd0, press}, 32'h2);
      raw[1] = 1'b0;
      for (int k = 1; k <= 6; k++) tick();
      chk("c1_rel", {28'd0, rel}, 32'h2);
      tick();

      // Auto-repeat on channel 2, release coinciding with a due rpt
      raw[2] = 1'b1;
      for (int k = 1; k <= 6; k++) tick();
      chk("c2_press", {28'd0, press}, 32'h4);
      for (int k = 1; k <= 30; k++) begin
         tick();
         exp_rpt = (k >= RD && ((k - RD) % RP) == 0) ? 4'h4 : 4'h0;
         chk("c2_rpt", {28'd0, rpt}, {28'd0, exp_rpt});
         chk("c2_press_low", {28'd0, press}, 32'd0);
         if (k == 5)  chk("c2_state_hold",   {30'd0, dbg_state[5:4]}, 32'd1);
         if (k == 13) chk("c2_state_repeat", {30'd0, dbg_state[5:4]}, 32'd2);
      end
      raw[2] = 1'b0;
      for (int k = 31; k <= 40; k++) begin
         tick();
         exp_rpt = (k == 33) ? 4'h4 : 4'h0;
         exp_rel = (k == 36) ? 4'h4 : 4'h0;
         chk("c2_rel_rpt", {28'd0, rpt}, {28'd0, exp_rpt});
         chk("c2_rel", {28'd0, rel}, {28'd0, exp_rel});
      end
      chk("c2_state_idle", {30'd0, dbg_state[5:4]}, 32'd0);

      // Reset mid-repeat while channel 2 is held
      raw[2] = 1'b1;
      for (int k = 1; k <= 6; k++) tick();
      chk("c2b_press", {28'd0, press}, 32'h4);
      for (int k = 1; k <= 12; k++) tick();
      chk("c2b_first_rpt", {28'd0, rpt}, 32'h4);
      rst_ext = 1'b1;
      tick();
      chk_quiet("mid_reset");
      chk("mid_reset_state", {24'd0, dbg_state}, 32'd0);
      rst_ext = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_quiet("after_reset");
      end
      tick();
      chk("c2b_repress", {28'd0, press}, 32'h4);
      chk("c2b_relevel", {28'd0, level}, 32'h4);
      raw[2] = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      chk("c2b_level_low", {28'd0, level}, 32'd0);

      // Simultaneous events on channels 0 and 1
      raw[1:0] = 2'b11;
      for (int k = 1; k <= 5; k++) tick();
      chk("sim_early", {28'd0, press}, 32'd0);
      tick();
      chk("sim_press", {28'd0, press}, 32'h3);
      raw[1:0] = 2'b00;
      for (int k = 1; k <= 6; k++) tick();
      chk("sim_rel", {28'd0, rel}, 32'h3);
      chk("sim_level", {28'd0, level}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 Parameter DB_CYCLES, default 1000000: consecutive mismatching cycles required to accept a level change (>=2).
REQ-003 Parameter REPEAT_EN, default 1: 1 enables auto-repeat pulses; 0 forces rpt to constant 0.
REQ-004 Parameter REPEAT_DELAY, default 50000000: cycles from press to first rpt pulse (>DB_CYCLES).
REQ-005 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent rpt pulses (>=2).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_ext  input  1  reset, synchronous, active-high.
REQ-008 raw  input  N_CH  asynchronous, bouncing switch inputs, active-high.
REQ-009 level  output  N_CH  debounced stable level per channel.
REQ-010 press  output  N_CH  one-cycle pulse on accepted 0->1 change.
REQ-011 rel  output  N_CH  one-cycle pulse on accepted 1->0 change.
REQ-012 rpt  output  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-013 Each raw bit SHALL pass through a 2-flop synchronizer; the second flop output is s[i].
REQ-014 Per channel, while s[i]==level[i] the debounce counter SHALL be 0; while s[i]!=level[i] it SHALL increment by 1 per cycle.
REQ-015 When the counter equals DB_CYCLES-1 and s[i]!=level[i], level[i] SHALL toggle on that edge and the counter SHALL return to 0.
REQ-016 Any single cycle of s[i]==level[i] SHALL clear the counter; glitches shorter than DB_CYCLES cycles SHALL never change level.
REQ-017 Latency: a clean raw step SHALL appear on level exactly 2+DB_CYCLES cycles after the first edge sampling the new value.
REQ-018 press[i] (rel[i]) SHALL be high exactly in the first cycle level[i] is 1 (0), and low otherwise; all outputs are registered.
REQ-019 Repeat FSM per channel, states IDLE, HOLD, REPEAT; IDLE->HOLD on press; HOLD->REPEAT when hold counter reaches REPEAT_DELAY-1, emitting rpt; in REPEAT, rpt every REPEAT_PERIOD cycles; any state ->IDLE on rel, counter cleared.
REQ-020 First rpt SHALL occur REPEAT_DELAY cycles after the press cycle; the k-th subsequent rpt REPEAT_DELAY+k*REPEAT_PERIOD cycles after it.
REQ-021 rpt SHALL never coincide with press or rel; if release is accepted in the cycle a rpt would fire, rel wins and rpt stays 0.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 Counter widths SHALL be $clog2 of the largest value held +1; no counter shall wrap.

Reset
REQ-024 While rst_ext is high: synchronizers, counters, level, press, rel, rpt SHALL be 0 and every FSM in IDLE on the next edge.
REQ-025 Reset mid-operation SHALL discard partial debounce/hold progress; no pulse SHALL be emitted in the cycle after reset deasserts.
REQ-026 If raw is high through reset, press SHALL occur 2+DB_CYCLES cycles after the first cycle with rst_ext low.

Structure
REQ-027 Shared package button_pkg SHALL hold the repeat-state enum (IDLE, HOLD, REPEAT) and the default parameter constants.
REQ-028 One sub-module, button_channel (synchronizer, debounce counter, repeat FSM for one bit), SHALL be instantiated N_CH times via generate.
REQ-029 REPEAT_EN=0 SHALL remove the repeat logic by generate, not by gating outputs only.

Verification (bench params N_CH=4, DB_CYCLES=4, REPEAT_DELAY=12, REPEAT_PERIOD=3)
REQ-030 raw[0] 0->1 clean at cycle 10 -> level[0]=1 and press[0]=1 at cycle 16 only; rel/rpt stay 0.
REQ-031 raw[1] bounce pattern 1,0,1,1,0,1 then stable 1 -> no change during bounce; level[1] rises 6 cycles after last 0->1.
REQ-032 raw[2] held high 30 cycles after press at P -> rpt[2] at P+12, P+15, P+18, ...; release -> rel[2] once, rpt stops.
REQ-033 raw[3] pulse of 3 cycles -> level, press, rel all remain 0.
REQ-034 rst_ext asserted for 1 cycle at P+13 while raw[2] held -> all outputs 0, press[2] again 6 cycles after rst_ext falls.
REQ-035 raw[0] and raw[1] rise same cycle -> press[0] and press[1] assert in the same cycle.
